// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 unsigned MUL/MULHU/DIVU/REMU for the EX stage.
// Optional MULDIV_EARLY_OUT_EN: zero-operand ops skip the 32 iterations.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ID_EX_aluop,
  input  logic [31:0] EX_muldiv_a,
  input  logic [31:0] EX_muldiv_b,
  output logic        EX_stall,
  output logic        EX_muldiv_valid,
  output logic [31:0] EX_muldiv_result,
  output logic        EX_muldiv_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULHU,
    OP_DIVU,
    OP_REMU
  } op_t;

  state_t      state;
  state_t      state_nxt;
  op_t         op_q;
  op_t         op_in;
  logic        is_md;
  logic        start;
  logic        zero_op;
  logic        last;
  logic [4:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] prod;
  logic [63:0] prod_nxt;
  logic [32:0] psum;
  logic [31:0] rem;
  logic [31:0] rem_nxt;
  logic [31:0] quo;
  logic [31:0] quo_nxt;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] early_res;
  logic [31:0] final_res;

  always_comb begin
    is_md = 1'b1;
    op_in = OP_MUL;
    unique case (ID_EX_aluop)
      4'b1010: op_in = OP_MUL;
      4'b1011: op_in = OP_MULHU;
      4'b1100: op_in = OP_DIVU;
      4'b1101: op_in = OP_REMU;
      default: is_md = 1'b0;
    endcase
  end

  // Reset gating keeps stall low while reset is held.
  assign start = (state == IDLE) && is_md && !reset;
  assign last  = (cnt == 5'd31);

`ifdef MULDIV_EARLY_OUT_EN
  assign zero_op = (EX_muldiv_b == 32'd0) ||
                   ((EX_muldiv_a == 32'd0) && !op_in[1]);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    early_res = 32'd0;
    unique case (op_in)
      OP_MUL:   early_res = 32'd0;
      OP_MULHU: early_res = 32'd0;
      OP_DIVU:  early_res = 32'hFFFF_FFFF;
      OP_REMU:  early_res = EX_muldiv_a;
    endcase
  end

  // Shift-add multiply: multiplier lives in prod[31:0].
  assign psum     = {1'b0, prod[63:32]}
                  + (prod[0] ? {1'b0, a_q} : 33'd0);
  assign prod_nxt = {psum, prod[31:1]};

  // Restoring divide: dividend shifts out of quo as quotient shifts in.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, b_q};
  assign rem_nxt = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_nxt = {quo[30:0], ~diff[32]};

  always_comb begin
    final_res = 32'd0;
    unique case (op_q)
      OP_MUL:   final_res = prod_nxt[31:0];
      OP_MULHU: final_res = prod_nxt[63:32];
      OP_DIVU:  final_res = quo_nxt;
      OP_REMU:  final_res = rem_nxt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_op ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_q             <= OP_MUL;
      cnt              <= 5'd0;
      a_q              <= 32'd0;
      b_q              <= 32'd0;
      prod             <= 64'd0;
      rem              <= 32'd0;
      quo              <= 32'd0;
      EX_muldiv_result <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        op_q <= op_in;
        a_q  <= EX_muldiv_a;
        b_q  <= EX_muldiv_b;
        prod <= {32'd0, EX_muldiv_b};
        rem  <= 32'd0;
        quo  <= EX_muldiv_a;
        cnt  <= 5'd0;
        if (zero_op) begin
          EX_muldiv_result <= early_res;
        end
      end else if (state == BUSY) begin
        prod <= prod_nxt;
        rem  <= rem_nxt;
        quo  <= quo_nxt;
        cnt  <= cnt + 5'd1;
        if (last) begin
          EX_muldiv_result <= final_res;
        end
      end
    end
  end

  assign EX_muldiv_busy  = (state == BUSY);
  assign EX_muldiv_valid = (state == DONE);
  assign EX_stall        = start || (state == BUSY);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of the iterative mul/div unit.
// Expected latencies follow the MULDIV_EARLY_OUT_EN build setting.
module tb_ex_muldiv_unit;

  localparam logic [3:0] ADD   = 4'b0000;
  localparam logic [3:0] MUL   = 4'b1010;
  localparam logic [3:0] MULHU = 4'b1011;
  localparam logic [3:0] DIVU  = 4'b1100;
  localparam logic [3:0] REMU  = 4'b1101;
  localparam int FULL = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ID_EX_aluop;
  logic [31:0] EX_muldiv_a;
  logic [31:0] EX_muldiv_b;
  logic        EX_stall;
  logic        EX_muldiv_valid;
  logic [31:0] EX_muldiv_result;
  logic        EX_muldiv_busy;

  int checks = 0;
  int failures = 0;

  ex_muldiv_unit dut (
    .clk              (clk),
    .reset            (reset),
    .ID_EX_aluop      (ID_EX_aluop),
    .EX_muldiv_a      (EX_muldiv_a),
    .EX_muldiv_b      (EX_muldiv_b),
    .EX_stall         (EX_stall),
    .EX_muldiv_valid  (EX_muldiv_valid),
    .EX_muldiv_result (EX_muldiv_result),
    .EX_muldiv_busy   (EX_muldiv_busy)
  );

  always #5 clk = ~clk;

  function automatic logic is_md(input logic [3:0] op);
    return (op == MUL) || (op == MULHU) || (op == DIVU) || (op == REMU);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic run(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat,
                     input bit scr, input logic [3:0] nxt);
    int n;
    int st;
    n  = 0;
    st = 0;
    ID_EX_aluop = op;
    EX_muldiv_a = a;
    EX_muldiv_b = b;
    #1;
    chk({tag, "_stall_c0"}, {31'd0, EX_stall}, 32'd1);
    while (!EX_muldiv_valid && n < 40) begin
      st += int'(EX_stall);
      if (scr && n == 5) begin
        EX_muldiv_a = $urandom;
        EX_muldiv_b = $urandom;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, EX_muldiv_valid}, 32'd1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_stall_cycles"}, st, lat);
    chk({tag, "_result"}, EX_muldiv_result, exp);
    chk({tag, "_stall_done"}, {31'd0, EX_stall}, 32'd0);
    ID_EX_aluop = nxt;
    @(posedge clk);
    #1;
    chk({tag, "_valid_pulse"}, {31'd0, EX_muldiv_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, EX_muldiv_busy}, 32'd0);
    chk({tag, "_stall_next"}, {31'd0, EX_stall}, {31'd0, is_md(nxt)});
  endtask

  initial begin
    reset       = 1'b1;
    ID_EX_aluop = ADD;
    EX_muldiv_a = 32'd0;
    EX_muldiv_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", EX_muldiv_result, 32'd0);
    chk("rst_valid", {31'd0, EX_muldiv_valid}, 32'd0);
    chk("rst_busy", {31'd0, EX_muldiv_busy}, 32'd0);
    chk("rst_stall", {31'd0, EX_stall}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("add_stall", {31'd0, EX_stall}, 32'd0);
    chk("add_busy", {31'd0, EX_muldiv_busy}, 32'd0);

    run("mul_7x6", MUL, 32'd7, 32'd6, 32'd42, FULL, 1'b0, ADD);
    run("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, FULL, 1'b0, ADD);
    run("mul_ff", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0001, FULL, 1'b0, ADD);
    run("mulhu_2p33", MULHU, 32'h8000_0000, 32'd4, 32'd2, FULL, 1'b0, ADD);
    run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, FULL, 1'b0, REMU);
    run("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, FULL, 1'b0, ADD);
    run("divu_by0", DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, ZLAT, 1'b0, ADD);
    run("remu_by0", REMU, 32'h1234, 32'd0, 32'h1234, ZLAT, 1'b0, ADD);
    run("mul_a0", MUL, 32'd0, 32'd5, 32'd0, ZLAT, 1'b0, ADD);
    run("mul_scr", MUL, 32'd123456, 32'd1000, 32'd123456000,
        FULL, 1'b1, ADD);
    run("divu_scr", DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555,
        FULL, 1'b1, ADD);

    ID_EX_aluop = MUL;
    EX_muldiv_a = 32'd5;
    EX_muldiv_b = 32'd9;
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", {31'd0, EX_muldiv_busy}, 32'd1);
    #2;
    ID_EX_aluop = ADD;
    reset = 1'b1;
    #1;
    chk("arst_stall", {31'd0, EX_stall}, 32'd0);
    chk("arst_busy", {31'd0, EX_muldiv_busy}, 32'd0);
    chk("arst_valid", {31'd0, EX_muldiv_valid}, 32'd0);
    chk("arst_result", EX_muldiv_result, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_stall", {31'd0, EX_stall}, 32'd0);
    chk("post_rst_busy", {31'd0, EX_muldiv_busy}, 32'd0);

    run("mul_5x9", MUL, 32'd5, 32'd9, 32'd45, FULL, 1'b0, ADD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
